// File: rtl/stage_mm.sv
`default_nettype none
// ============================================================================
// Module   : stage_mm
// Purpose  : Memory pipeline stage. Forwards ALU results, or runs one
//            load/store per instruction on a req/ack data-memory port. Store
//            data is lane-replicated with byte enables. Load data is
//            extracted from its byte lane and sign- or zero-extended. Upstream
//            stages are held while an access is outstanding.
// Ports    : clk, rst (sync, active-high), en (global freeze), stall
//            (downstream hold), flush (incoming bubble)
//            reg_wr, reg_addr_rd          : writeback controls of the slot
//            mem_rd, mem_wr, mem_size,
//            mem_unsigned                 : memory-op controls
//            alu_res, store_data          : address / forwarded result, rs2
//            dmem_req/we/addr/wdata/be    : registered memory request
//            dmem_ack, dmem_rdata         : single-cycle completion + data
//            out_flush, out_reg_wr,
//            out_reg_addr_rd, out_data    : registered writeback slot
//            out_misaligned               : pulse, access dropped
//            out_stall_req                : combinational upstream hold
// Revision : 1.0 - initial release
// ============================================================================
module stage_mm #(
   parameter int DATA_W      = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int DMEM_ADDR_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   reg_wr,
   input  logic [REG_ADDR_W-1:0]  reg_addr_rd,
   input  logic                   mem_rd,
   input  logic                   mem_wr,
   input  logic [1:0]             mem_size,
   input  logic                   mem_unsigned,
   input  logic [DATA_W-1:0]      alu_res,
   input  logic [DATA_W-1:0]      store_data,
   output logic                   dmem_req,
   output logic                   dmem_we,
   output logic [DMEM_ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0]      dmem_wdata,
   output logic [3:0]             dmem_be,
   input  logic                   dmem_ack,
   input  logic [DATA_W-1:0]      dmem_rdata,
   output logic                   out_flush,
   output logic                   out_reg_wr,
   output logic [REG_ADDR_W-1:0]  out_reg_addr_rd,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_misaligned,
   output logic                   out_stall_req
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t                r_state;

   // Attributes of the access in flight, latched at request launch
   logic [1:0]            r_size;
   logic                  r_unsigned;
   logic [1:0]            r_lane;
   logic                  r_is_load;
   logic                  r_reg_wr;
   logic [REG_ADDR_W-1:0] r_rd;

   // Result parked while downstream stalls past the ack
   logic [DATA_W-1:0]     r_hold_data;
   logic                  r_hold_reg_wr;

   logic                  w_memop;
   logic                  w_is_load;
   logic [1:0]            w_lane;
   logic                  w_misaligned;
   logic [DATA_W-1:0]     w_wdata;
   logic [3:0]            w_be;
   logic [DATA_W-1:0]     w_shifted;
   logic [DATA_W-1:0]     w_load;

   // Both mem_rd and mem_wr set is a load
   assign w_memop   = ~flush & (mem_rd | mem_wr);
   assign w_is_load = mem_rd;
   assign w_lane    = alu_res[1:0];

   // Reserved size 3 behaves as a word, so any size with bit 1 set needs
   // full word alignment.
   assign w_misaligned = ((mem_size == 2'd1) & w_lane[0]) |
                         (mem_size[1] & (w_lane != 2'b00));

   // Store data replicated across all lanes; the byte enables select which
   // lanes the memory actually writes.
   always_comb begin
      w_wdata = store_data;
      w_be    = 4'b1111;
      case (mem_size)
         2'd0: begin
            w_wdata = {4{store_data[7:0]}};
            w_be    = 4'b0001 << w_lane;
         end
         2'd1: begin
            w_wdata = {2{store_data[15:0]}};
            w_be    = 4'b0011 << w_lane;
         end
         default: begin
            w_wdata = store_data;
            w_be    = 4'b1111;
         end
      endcase
   end

   // Load lane extraction uses the latched lane/size, since the execute
   // stage may have moved on by the time the ack arrives.
   assign w_shifted = dmem_rdata >> {r_lane, 3'b000};

   always_comb begin
      w_load = dmem_rdata;
      case (r_size)
         2'd0:    w_load = {{(DATA_W-8){~r_unsigned & w_shifted[7]}},
                            w_shifted[7:0]};
         2'd1:    w_load = {{(DATA_W-16){~r_unsigned & w_shifted[15]}},
                            w_shifted[15:0]};
         default: w_load = dmem_rdata;
      endcase
   end

   // Drops in the ack cycle so the execute stage advances on the same edge
   // at which the result is registered here.
   assign out_stall_req = ((r_state == S_IDLE) & w_memop & ~w_misaligned) |
                          ((r_state == S_WAIT) & ~dmem_ack) |
                          (r_state == S_HOLD);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         dmem_req        <= 1'b0;
         dmem_we         <= 1'b0;
         dmem_be         <= 4'b0000;
         dmem_addr       <= '0;
         dmem_wdata      <= '0;
         out_flush       <= 1'b1;
         out_reg_wr      <= 1'b0;
         out_reg_addr_rd <= '0;
         out_data        <= '0;
         out_misaligned  <= 1'b0;
         r_size          <= 2'd0;
         r_unsigned      <= 1'b0;
         r_lane          <= 2'd0;
         r_is_load       <= 1'b0;
         r_reg_wr        <= 1'b0;
         r_rd            <= '0;
         r_hold_data     <= '0;
         r_hold_reg_wr   <= 1'b0;
      end else if (en) begin
         case (r_state)
            S_IDLE: begin
               // With stall high everything holds and nothing launches
               if (!stall) begin
                  out_reg_addr_rd <= reg_addr_rd;
                  out_data        <= alu_res;
                  if (w_memop && !w_misaligned) begin
                     dmem_req       <= 1'b1;
                     dmem_we        <= mem_wr & ~mem_rd;
                     dmem_addr      <= {alu_res[DMEM_ADDR_W-1:2], 2'b00};
                     dmem_wdata     <= w_wdata;
                     dmem_be        <= w_is_load ? 4'b1111 : w_be;
                     r_size         <= mem_size;
                     r_unsigned     <= mem_unsigned;
                     r_lane         <= w_lane;
                     r_is_load      <= w_is_load;
                     r_reg_wr       <= reg_wr;
                     r_rd           <= reg_addr_rd;
                     out_flush      <= 1'b1;
                     out_reg_wr     <= 1'b0;
                     out_misaligned <= 1'b0;
                     r_state        <= S_WAIT;
                  end else if (w_memop) begin
                     // Misaligned access is dropped; slot becomes a bubble
                     out_flush      <= 1'b1;
                     out_reg_wr     <= 1'b0;
                     out_misaligned <= 1'b1;
                  end else begin
                     out_flush      <= flush;
                     out_reg_wr     <= reg_wr & ~flush;
                     out_misaligned <= 1'b0;
                  end
               end
            end

            S_WAIT: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  dmem_be  <= 4'b0000;
                  if (!stall) begin
                     out_data        <= w_load;
                     out_flush       <= 1'b0;
                     out_reg_wr      <= r_reg_wr & r_is_load;
                     out_reg_addr_rd <= r_rd;
                     out_misaligned  <= 1'b0;
                     r_state         <= S_IDLE;
                  end else begin
                     r_hold_data   <= w_load;
                     r_hold_reg_wr <= r_reg_wr & r_is_load;
                     r_state       <= S_HOLD;
                  end
               end
            end

            S_HOLD: begin
               if (!stall) begin
                  out_data        <= r_hold_data;
                  out_flush       <= 1'b0;
                  out_reg_wr      <= r_hold_reg_wr;
                  out_reg_addr_rd <= r_rd;
                  out_misaligned  <= 1'b0;
                  r_state         <= S_IDLE;
               end
            end

            default: begin
               r_state  <= S_IDLE;
               dmem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stage_mm.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_mm
// Purpose  : Directed self-checking bench for stage_mm: ALU forward, signed
//            byte load, half store lanes, misaligned word load, unsigned
//            half load through HOLD, reset during WAIT, and enable freeze.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_mm;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        stall;
   logic        flush;
   logic        reg_wr;
   logic [4:0]  reg_addr_rd;
   logic        mem_rd;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [31:0] alu_res;
   logic [31:0] store_data;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        out_flush;
   logic        out_reg_wr;
   logic [4:0]  out_reg_addr_rd;
   logic [31:0] out_data;
   logic        out_misaligned;
   logic        out_stall_req;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stage_mm #(
      .DATA_W      (32),
      .REG_ADDR_W  (5),
      .DMEM_ADDR_W (32)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .stall           (stall),
      .flush           (flush),
      .reg_wr          (reg_wr),
      .reg_addr_rd     (reg_addr_rd),
      .mem_rd          (mem_rd),
      .mem_wr          (mem_wr),
      .mem_size        (mem_size),
      .mem_unsigned    (mem_unsigned),
      .alu_res         (alu_res),
      .store_data      (store_data),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .dmem_be         (dmem_be),
      .dmem_ack        (dmem_ack),
      .dmem_rdata      (dmem_rdata),
      .out_flush       (out_flush),
      .out_reg_wr      (out_reg_wr),
      .out_reg_addr_rd (out_reg_addr_rd),
      .out_data        (out_data),
      .out_misaligned  (out_misaligned),
      .out_stall_req   (out_stall_req)
   );

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      flush        = 1'b1;
      reg_wr       = 1'b0;
      reg_addr_rd  = 5'd0;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      mem_size     = 2'd0;
      mem_unsigned = 1'b0;
      alu_res      = 32'h0;
      store_data   = 32'h0;
   endtask

   task automatic memop(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] rdst,
                        input logic wen);
      flush        = 1'b0;
      mem_rd       = rd;
      mem_wr       = wr;
      mem_size     = sz;
      mem_unsigned = uns;
      alu_res      = addr;
      store_data   = sd;
      reg_addr_rd  = rdst;
      reg_wr       = wen;
   endtask

   initial begin
      rst        = 1'b1;
      en         = 1'b1;
      stall      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      bubble();
      tick();
      tick();
      check("rst_flush",   {31'b0, out_flush},      32'h1);
      check("rst_reg_wr",  {31'b0, out_reg_wr},     32'h0);
      check("rst_req",     {31'b0, dmem_req},       32'h0);
      check("rst_data",    out_data,                32'h0);
      check("rst_be",      {28'b0, dmem_be},        32'h0);
      check("rst_misal",   {31'b0, out_misaligned}, 32'h0);
      rst = 1'b0;

      // ---- ALU forward ----
      memop(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1);
      @(negedge clk);
      check("alu_stallreq", {31'b0, out_stall_req}, 32'h0);
      tick();
      check("alu_data",  out_data,                 32'h1234);
      check("alu_regwr", {31'b0, out_reg_wr},      32'h1);
      check("alu_flush", {31'b0, out_flush},       32'h0);
      check("alu_rd",    {27'b0, out_reg_addr_rd}, 32'd5);
      check("alu_req",   {31'b0, dmem_req},        32'h0);
      bubble();
      tick();

      // ---- LB signed at 0x103, ack two cycles after request cycle ----
      memop(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd7, 1'b1);
      @(negedge clk);
      check("lb_stallreq0", {31'b0, out_stall_req}, 32'h1);
      tick();
      check("lb_req",   {31'b0, dmem_req},  32'h1);
      check("lb_addr",  dmem_addr,          32'h100);
      check("lb_we",    {31'b0, dmem_we},   32'h0);
      check("lb_flush", {31'b0, out_flush}, 32'h1);
      @(negedge clk);
      check("lb_stallreq1", {31'b0, out_stall_req}, 32'h1);
      tick();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h80FF_0000;
      @(negedge clk);
      check("lb_stallreq_ack", {31'b0, out_stall_req}, 32'h0);
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      bubble();
      check("lb_data",  out_data,                 32'hFFFF_FF80);
      check("lb_flush_out", {31'b0, out_flush},   32'h0);
      check("lb_regwr", {31'b0, out_reg_wr},      32'h1);
      check("lb_rd",    {27'b0, out_reg_addr_rd}, 32'd7);
      check("lb_req_off", {31'b0, dmem_req},      32'h0);

      // ---- SH at 0x202 ----
      memop(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'hABCD_1234, 5'd0, 1'b0);
      tick();
      check("sh_addr",  dmem_addr,         32'h200);
      check("sh_be",    {28'b0, dmem_be},  32'hC);
      check("sh_wdata", dmem_wdata,        32'h1234_1234);
      check("sh_we",    {31'b0, dmem_we},  32'h1);
      check("sh_req",   {31'b0, dmem_req}, 32'h1);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      bubble();
      check("sh_regwr", {31'b0, out_reg_wr}, 32'h0);
      check("sh_flush", {31'b0, out_flush},  32'h0);
      check("sh_req_off", {31'b0, dmem_req}, 32'h0);

      // ---- LW misaligned at 0x101 ----
      memop(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 5'd3, 1'b1);
      @(negedge clk);
      check("lwm_stallreq", {31'b0, out_stall_req}, 32'h0);
      tick();
      bubble();
      check("lwm_req",   {31'b0, dmem_req},       32'h0);
      check("lwm_misal", {31'b0, out_misaligned}, 32'h1);
      check("lwm_flush", {31'b0, out_flush},      32'h1);
      check("lwm_regwr", {31'b0, out_reg_wr},     32'h0);
      tick();
      check("lwm_pulse_end", {31'b0, out_misaligned}, 32'h0);

      // ---- LHU at 0x002, ack under stall -> HOLD for 3 stalled cycles ----
      memop(1'b1, 1'b0, 2'd1, 1'b1, 32'h002, 32'h0, 5'd9, 1'b1);
      tick();
      check("lhu_req",  {31'b0, dmem_req}, 32'h1);
      check("lhu_addr", dmem_addr,         32'h0);
      stall      = 1'b1;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hF00D_0000;
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      bubble();
      check("lhu_req_off", {31'b0, dmem_req}, 32'h0);
      check("lhu_held_flush", {31'b0, out_flush}, 32'h1);
      @(negedge clk);
      check("lhu_hold_stallreq", {31'b0, out_stall_req}, 32'h1);
      tick();
      tick();
      stall = 1'b0;
      check("lhu_still_bubble", {31'b0, out_flush}, 32'h1);
      tick();
      check("lhu_data",  out_data,                 32'h0000_F00D);
      check("lhu_flush", {31'b0, out_flush},       32'h0);
      check("lhu_regwr", {31'b0, out_reg_wr},      32'h1);
      check("lhu_rd",    {27'b0, out_reg_addr_rd}, 32'd9);
      @(negedge clk);
      check("lhu_idle_stallreq", {31'b0, out_stall_req}, 32'h0);
      tick();

      // ---- reset during WAIT, late ack ignored ----
      memop(1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 5'd4, 1'b1);
      tick();
      check("rw_req", {31'b0, dmem_req}, 32'h1);
      rst = 1'b1;
      bubble();
      tick();
      rst = 1'b0;
      check("rw_req_off", {31'b0, dmem_req},  32'h0);
      check("rw_flush",   {31'b0, out_flush}, 32'h1);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("rw_stallreq", {31'b0, out_stall_req}, 32'h0);
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      check("rw_ack_ignored_flush", {31'b0, out_flush}, 32'h1);
      check("rw_ack_ignored_data",  out_data,           32'h0);
      check("rw_ack_ignored_regwr", {31'b0, out_reg_wr}, 32'h0);

      // ---- en = 0 freezes outputs ----
      en = 1'b0;
      memop(1'b0, 1'b0, 2'd2, 1'b0, 32'h55, 32'h0, 5'd2, 1'b1);
      tick();
      check("en0_flush", {31'b0, out_flush}, 32'h1);
      check("en0_data",  out_data,           32'h0);
      en = 1'b1;
      tick();
      check("en1_data",  out_data,            32'h55);
      check("en1_regwr", {31'b0, out_reg_wr}, 32'h1);
      bubble();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
